// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared multiply/divide sequencer constants and state encoding
package muldiv_pkg;

    localparam int W           = 32;
    localparam int MULT_CYCLES = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_CAPT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        RUN  = ST_RUN,
        CAPT = ST_CAPT
    } muldiv_state_e;

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// rtl/mult_hilo_ctrl_if.sv - control-side and multiplier-side signals of the HI/LO sequencer
interface mult_hilo_ctrl_if #(parameter int W = muldiv_pkg::W);
    import muldiv_pkg::*;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic [W-1:0] mult_hi;
    logic [W-1:0] mult_lo;
    logic [W-1:0] mult_a;
    logic [W-1:0] mult_b;
    logic         mult_load;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, op_a, op_b, mthi, mtlo, wdata, mult_hi, mult_lo,
        input  mult_a, mult_b, mult_load, hi, lo, busy, done, err
    );

    modport slave (
        input  start, op_a, op_b, mthi, mtlo, wdata, mult_hi, mult_lo,
        output mult_a, mult_b, mult_load, hi, lo, busy, done, err
    );

endinterface

// File: rtl/mult_hilo_ctrl_hilo_regs.sv
// rtl/mult_hilo_ctrl_hilo_regs.sv - architectural HI/LO pair, loaded from the product or a move
module hilo_regs
    import muldiv_pkg::*;
#(
    parameter int WIDTH = muldiv_pkg::W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic             sel_capt,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= sel_capt ? mult_hi : wdata;
            if (lo_we) lo <= sel_capt ? mult_lo : wdata;
        end
    end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// rtl/mult_hilo_ctrl.sv - MULT sequencer: operand latch, load strobe, iteration count, HI/LO capture
module mult_hilo_ctrl #(
    parameter int W           = muldiv_pkg::W,
    parameter int MULT_CYCLES = muldiv_pkg::MULT_CYCLES
) (
    input logic             clk,
    input logic             reset,
    mult_hilo_ctrl_if.slave bus
);
    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(MULT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_CYCLES - 1);

    muldiv_state_e    state, state_d;
    logic [CNT_W-1:0] count, count_d;
    logic [W-1:0]     mult_a_q, mult_b_q;
    logic             done_q, err_q;
    logic             accept;
    logic             busy;
    logic             capt;
    logic             move_ok;

    assign busy    = (state != IDLE);
    assign capt    = (state == CAPT);
    // A start in IDLE takes priority; a move issued alongside it is dropped silently.
    assign move_ok = (state == IDLE) && !bus.start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            mult_a_q <= '0;
            mult_b_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state  <= state_d;
            count  <= count_d;
            done_q <= capt;
            err_q  <= busy && (bus.start || bus.mthi || bus.mtlo);
            if (accept) begin
                mult_a_q <= bus.op_a;
                mult_b_q <= bus.op_b;
            end
        end
    end

    always_comb begin
        state_d = state;
        count_d = count;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = '0;
                state_d = RUN;
            end
            RUN: begin
                count_d = count + 1'b1;
                if (count == LAST_CNT) state_d = CAPT;
            end
            CAPT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mult_a    = mult_a_q;
    assign bus.mult_b    = mult_b_q;
    assign bus.mult_load = (state == LOAD);
    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    hilo_regs #(.WIDTH(W)) u_hilo_regs (
        .clk      (clk),
        .reset    (reset),
        .hi_we    (capt || (move_ok && bus.mthi)),
        .lo_we    (capt || (move_ok && bus.mtlo)),
        .sel_capt (capt),
        .mult_hi  (bus.mult_hi),
        .mult_lo  (bus.mult_lo),
        .wdata    (bus.wdata),
        .hi       (bus.hi),
        .lo       (bus.lo)
    );

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb/tb_mult_hilo_ctrl.sv - randomized and directed checks of mult_hilo_ctrl against a cycle-phase model
module tb_mult_hilo_ctrl;

    localparam int MULT_CYCLES = 32;
    localparam int CAPT_PH     = MULT_CYCLES + 2;

    logic clk;
    logic reset;

    mult_hilo_ctrl_if #(.W(32)) bus ();

    mult_hilo_ctrl #(.W(32), .MULT_CYCLES(MULT_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: m_ph counts cycles since an accepted start (0 = idle, 1 = load, CAPT_PH = capture).
    int          m_ph   = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;
    logic [63:0] m_prod = '0;
    logic        m_done = 1'b0;
    logic        m_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        longint pa, pb;
        if (reset) begin
            m_ph = 0; m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
            m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = (m_ph == CAPT_PH);
            m_err  = (m_ph != 0) && (bus.start || bus.mthi || bus.mtlo);
            if (m_ph == CAPT_PH) begin
                m_hi = m_prod[63:32];
                m_lo = m_prod[31:0];
                m_ph = 0;
            end else if (m_ph != 0) begin
                m_ph++;
            end else if (bus.start) begin
                m_a    = bus.op_a;
                m_b    = bus.op_b;
                pa     = longint'($signed(bus.op_a));
                pb     = longint'($signed(bus.op_b));
                m_prod = 64'(pa * pb);
                m_ph   = 1;
            end else begin
                if (bus.mthi) m_hi = bus.wdata;
                if (bus.mtlo) m_lo = bus.wdata;
            end
        end
    endtask

    task automatic compare_all();
        if (chk_en) begin
            chk("busy",      32'(bus.busy),      32'(m_ph != 0));
            chk("mult_load", 32'(bus.mult_load), 32'(m_ph == 1));
            chk("done",      32'(bus.done),      32'(m_done));
            chk("err",       32'(bus.err),       32'(m_err));
            chk("hi",        bus.hi,             m_hi);
            chk("lo",        bus.lo,             m_lo);
            chk("mult_a",    bus.mult_a,         m_a);
            chk("mult_b",    bus.mult_b,         m_b);
        end
    endtask

    // The multiplier's outputs carry the product only during capture; otherwise noise.
    task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic h, input logic l, input logic [31:0] wd, input logic rst);
        bus.start = s;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.mthi  = h;
        bus.mtlo  = l;
        bus.wdata = wd;
        reset     = rst;
        if (m_ph == CAPT_PH) begin
            bus.mult_hi = m_prod[63:32];
            bus.mult_lo = m_prod[31:0];
        end else begin
            bus.mult_hi = $urandom;
            bus.mult_lo = $urandom;
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, 1'b0, 1'b0, $urandom, 1'b0);
    endtask

    task automatic start_mult(input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, a, b, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.wdata = '0; bus.mult_hi = '0; bus.mult_lo = '0;
        reset = 1'b1;

        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_en = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);

        // 3 * 4
        start_mult(32'd3, 32'd4);
        chk("t1_load", 32'(bus.mult_load), 32'h1);
        idle(33);
        chk("t1_busy34", 32'(bus.busy), 32'h1);
        idle(1);
        chk("t1_done", 32'(bus.done), 32'h1);
        chk("t1_hi", bus.hi, 32'h00000000);
        chk("t1_lo", bus.lo, 32'h0000000C);

        // -1 * 5
        start_mult(32'hFFFFFFFF, 32'd5);
        idle(34);
        chk("t2_hi", bus.hi, 32'hFFFFFFFF);
        chk("t2_lo", bus.lo, 32'hFFFFFFFB);

        // most-negative squared; prior product must hold until done
        start_mult(32'h80000000, 32'h80000000);
        idle(33);
        chk("t3_hold_lo", bus.lo, 32'hFFFFFFFB);
        idle(1);
        chk("t3_hi", bus.hi, 32'h40000000);
        chk("t3_lo", bus.lo, 32'h00000000);

        // moves
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
        chk("t4_mthi", bus.hi, 32'hDEADBEEF);
        start_mult(32'd2, 32'd3);
        idle(4);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0);
        chk("t4_err", 32'(bus.err), 32'h1);
        chk("t4_lo_kept", bus.lo, 32'h00000000);
        idle(29);
        chk("t4_done", 32'(bus.done), 32'h1);
        chk("t4_lo", bus.lo, 32'h00000006);

        // second start mid-run
        start_mult(32'd9, 32'd11);
        idle(9);
        start_mult(32'd100, 32'd100);
        chk("t5_err", 32'(bus.err), 32'h1);
        chk("t5_a_kept", bus.mult_a, 32'd9);
        idle(24);
        chk("t5_done", 32'(bus.done), 32'h1);
        chk("t5_lo", bus.lo, 32'd99);

        // reset mid-operation, then 7 * -2
        start_mult(32'd5, 32'd5);
        idle(19);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_busy", 32'(bus.busy), 32'h0);
        chk("t6_lo", bus.lo, 32'h0);
        idle(15);
        chk("t6_no_done", 32'(bus.done), 32'h0);
        start_mult(32'd7, 32'hFFFFFFFE);
        idle(34);
        chk("t6_hi", bus.hi, 32'hFFFFFFFF);
        chk("t6_lo2", bus.lo, 32'hFFFFFFF2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) == 0), $urandom, $urandom,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom,
                  ($urandom_range(0, 299) == 0));
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
